// File: rtl/sum_accumulator_if.sv
// Bundle of the adder-result input stream, the frame-total output stream and the frame abort.
// Both streams use valid/ready: a transfer happens on a rising edge where valid && ready are both high.
interface sum_accumulator_if #(
    parameter int ACC_W = 8
);
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_total;
    logic             out_ovf;

    modport master (
        output clear, in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_total, out_ovf
    );

    modport slave (
        input  clear, in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_total, out_ovf
    );
endinterface

// File: rtl/sum_accumulator.sv
// Sums a frame of COUNT 3-bit adder results into an ACC_W-bit total with a sticky carry flag,
// then holds the total on the output stream until it is taken.
module sum_accumulator #(
    parameter int COUNT = 4,
    parameter int ACC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sum_accumulator_if.slave  bus,
    output logic              dbg_state
);
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic             tovf_q, tovf_d;

    logic             accept;
    logic             out_fire;
    logic [ACC_W:0]   sum_ext;

    assign accept   = bus.in_valid && (state_q == ACCUM);
    assign out_fire = bus.out_ready && (state_q == HOLD);
    // One extra bit on the adder catches the carry out of the accumulator.
    assign sum_ext  = {1'b0, acc_q} + {{(ACC_W-2){1'b0}}, bus.in_sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            total_q <= '0;
            tovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            total_q <= total_d;
            tovf_q  <= tovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        total_d = total_q;
        tovf_d  = tovf_q;
        if (bus.clear || out_fire) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            total_d = '0;
            tovf_d  = 1'b0;
        end else if (accept) begin
            acc_d = sum_ext[ACC_W-1:0];
            ovf_d = ovf_q | sum_ext[ACC_W];
            if (cnt_q == LAST_CNT) begin
                state_d = HOLD;
                cnt_d   = '0;
                total_d = sum_ext[ACC_W-1:0];
                tovf_d  = ovf_q | sum_ext[ACC_W];
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Handshake flags decode only the state register, never the incoming valid/ready.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_total = total_q;
    assign bus.out_ovf   = tovf_q;
    assign dbg_state     = state_q;
endmodule
